// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl_pkg
// Purpose  : Shared encodings and defaults for the multiply/divide sequencer.
// Revision : 1.0
// ============================================================================
package mdu_ctrl_pkg;

   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;
   localparam logic [2:0] MDU_MTHI  = 3'd4;
   localparam logic [2:0] MDU_MTLO  = 3'd5;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;

   // Multi-cycle ops are exactly the four arithmetic encodings.
   function automatic logic is_arith(input logic [2:0] op);
      return (op <= MDU_DIVU);
   endfunction

   function automatic logic is_div(input logic [2:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div32.sv
`default_nettype none
// ============================================================================
// Module   : mdu_div32
// Purpose  : Combinational 32-bit signed/unsigned divider with zero guard.
// Revision : 1.0
// ============================================================================
module mdu_div32 (
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        is_signed,
   output logic [31:0] quot,
   output logic [31:0] rem,
   output logic        div_zero
);

   logic        w_neg_a;
   logic        w_neg_b;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic [31:0] w_safe_b;
   logic [31:0] w_uquot;
   logic [31:0] w_urem;

   // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
   assign w_neg_a  = is_signed & dividend[31];
   assign w_neg_b  = is_signed & divisor[31];
   assign w_mag_a  = w_neg_a ? (32'd0 - dividend) : dividend;
   assign w_mag_b  = w_neg_b ? (32'd0 - divisor)  : divisor;
   assign div_zero = (divisor == 32'd0);
   assign w_safe_b = div_zero ? 32'd1 : w_mag_b;
   assign w_uquot  = w_mag_a / w_safe_b;
   assign w_urem   = w_mag_a % w_safe_b;

   // Quotient truncates toward zero; remainder follows the dividend sign.
   assign quot = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uquot) : w_uquot;
   assign rem  = w_neg_a ? (32'd0 - w_urem) : w_urem;

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl
// Purpose  : MDU sequencer: fixed-latency MULT/DIV, HI/LO ownership, stall.
// Revision : 1.0
// ============================================================================
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        cancel,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int c_cnt_w      = $clog2(c_max_cycles + 1);
   localparam logic [c_cnt_w-1:0] c_mult_ld = c_cnt_w'(MULT_CYCLES);
   localparam logic [c_cnt_w-1:0] c_div_ld  = c_cnt_w'(DIV_CYCLES);
   localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

   logic [0:0]         r_state;
   logic [0:0]         w_next_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [2:0]         r_op;
   logic [31:0]        r_a;
   logic [31:0]        r_b;
   logic [31:0]        r_hi;
   logic [31:0]        r_lo;

   logic               w_accept;
   logic               w_launch;
   logic               w_last;
   logic [63:0]        w_ext_a;
   logic [63:0]        w_ext_b;
   logic [63:0]        w_prod;
   logic [31:0]        w_quot;
   logic [31:0]        w_rem;
   logic               w_div_zero;

   assign w_accept = (r_state == ST_IDLE) & start & ~cancel;
   assign w_launch = w_accept & is_arith(op);
   assign w_last   = (r_state == ST_RUN) & (r_cnt == c_cnt_one);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (w_launch) w_next_state = ST_RUN;
         ST_RUN:  if (w_last)   w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Output logic; the start term lets the hazard unit freeze before busy rises.
   always_comb begin
      busy      = (r_state == ST_RUN);
      stall_req = busy | (start & is_arith(op) & ~cancel);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
         r_op  <= MDU_MULT;
         r_a   <= 32'd0;
         r_b   <= 32'd0;
      end else if (w_launch) begin
         r_cnt <= is_div(op) ? c_div_ld : c_mult_ld;
         r_op  <= op;
         r_a   <= rs_val;
         r_b   <= rt_val;
      end else if (r_state == ST_RUN) begin
         r_cnt <= r_cnt - c_cnt_one;
      end
   end

   // Low 64 bits of the extended product are correct for both signednesses.
   assign w_ext_a = is_signed_op(r_op) ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
   assign w_ext_b = is_signed_op(r_op) ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
   assign w_prod  = w_ext_a * w_ext_b;

   mdu_div32 u_div (
      .dividend  (r_a),
      .divisor   (r_b),
      .is_signed (is_signed_op(r_op)),
      .quot      (w_quot),
      .rem       (w_rem),
      .div_zero  (w_div_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hi <= 32'd0;
         r_lo <= 32'd0;
      end else if (w_last) begin
         if (is_div(r_op)) begin
            if (!w_div_zero) begin
               r_hi <= w_rem;
               r_lo <= w_quot;
            end
         end else begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
         end
      end else if (w_accept) begin
         if (op == MDU_MTHI) r_hi <= rs_val;
         if (op == MDU_MTLO) r_lo <= rs_val;
      end
   end

   assign hi = r_hi;
   assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_ctrl
// Purpose  : Self-checking bench for mdu_ctrl (vector table plus scoreboard).
// Revision : 1.0
// ============================================================================
module tb_mdu_ctrl;
   import mdu_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] rs_val = 32'd0;
   logic [31:0] rt_val = 32'd0;
   logic        cancel = 1'b0;
   logic        busy;
   logic        stall_req;
   logic [31:0] hi;
   logic [31:0] lo;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .cancel    (cancel),
      .busy      (busy),
      .stall_req (stall_req),
      .hi        (hi),
      .lo        (lo)
   );

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic [7:0]  cyc;
   } exp_t;

   typedef struct packed {
      logic [2:0]  op;
      logic        cancel;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [7:0]  cyc;
      logic        upd_hi;
      logic        upd_lo;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   localparam int NV = 13;
   vec_t        vecs [NV];
   exp_t        sb [$];
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] h, input logic [31:0] l, input logic [7:0] c);
      exp_t e;
      e.hi = h;
      e.lo = l;
      e.cyc = c;
      m_hi = h;
      m_lo = l;
      sb.push_back(e);
   endtask

   // Called just after a negedge; holds start for one cycle.
   task automatic issue(input logic [2:0] o, input logic c, input logic [31:0] a, input logic [31:0] b);
      start  = 1'b1;
      op     = o;
      cancel = c;
      rs_val = a;
      rt_val = b;
      #1;
      chk("stall_on_issue", {63'd0, stall_req}, {63'd0, (o <= MDU_DIVU) && !c});
      @(negedge clk);
      start  = 1'b0;
      cancel = 1'b0;
   endtask

   // Counts busy cycles (bounded), optionally injecting cancel or a stray start at cycle inj_at.
   task automatic wait_done(input string name, input int inj_at, input logic inj_start);
      exp_t e;
      int   n;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         if (n == inj_at) begin
            if (inj_start) begin
               start = 1'b1; op = MDU_DIV; rs_val = 32'd100; rt_val = 32'd7;
            end else begin
               cancel = 1'b1;
            end
            #1;
            chk({name, "_stall_busy"}, {63'd0, stall_req}, 64'd1);
         end else begin
            start = 1'b0;
            cancel = 1'b0;
         end
         @(negedge clk);
      end
      start  = 1'b0;
      cancel = 1'b0;
      if (sb.size() == 0) begin
         total++; bad++;
         $display("FAIL %s: scoreboard empty got 0 entries want 1", name);
      end else begin
         e = sb.pop_front();
         chk({name, "_cycles"}, 64'(n), 64'(e.cyc));
         chk({name, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
         chk({name, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{MDU_MULT,  1'b0, 32'hFFFFFFFE, 32'd3,        8'd5,  1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA};
      vecs[1]  = '{MDU_MULTU, 1'b0, 32'hFFFFFFFE, 32'd3,        8'd5,  1'b1, 1'b1, 32'h00000002, 32'hFFFFFFFA};
      vecs[2]  = '{MDU_DIV,   1'b0, 32'hFFFFFFF9, 32'd2,        8'd10, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{MDU_DIVU,  1'b0, 32'd7,        32'd0,        8'd10, 1'b0, 1'b0, 32'd0,        32'd0};
      vecs[4]  = '{MDU_DIV,   1'b0, 32'h80000000, 32'hFFFFFFFF, 8'd10, 1'b1, 1'b1, 32'h00000000, 32'h80000000};
      vecs[5]  = '{MDU_DIVU,  1'b0, 32'hFFFFFFFF, 32'h10,       8'd10, 1'b1, 1'b1, 32'h0000000F, 32'h0FFFFFFF};
      vecs[6]  = '{MDU_DIV,   1'b0, 32'd7,        32'hFFFFFFFE, 8'd10, 1'b1, 1'b1, 32'h00000001, 32'hFFFFFFFD};
      vecs[7]  = '{MDU_MULT,  1'b0, 32'h80000000, 32'h80000000, 8'd5,  1'b1, 1'b1, 32'h40000000, 32'h00000000};
      vecs[8]  = '{MDU_MULTU, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd5,  1'b1, 1'b1, 32'hFFFFFFFE, 32'h00000001};
      vecs[9]  = '{MDU_MTHI,  1'b0, 32'hCAFEF00D, 32'd0,        8'd0,  1'b1, 1'b0, 32'hCAFEF00D, 32'd0};
      vecs[10] = '{MDU_MTLO,  1'b0, 32'h0BADBEEF, 32'd0,        8'd0,  1'b0, 1'b1, 32'd0,        32'h0BADBEEF};
      vecs[11] = '{3'd6,      1'b0, 32'h11111111, 32'd1,        8'd0,  1'b0, 1'b0, 32'd0,        32'd0};
      vecs[12] = '{MDU_MULT,  1'b1, 32'd9,        32'd9,        8'd0,  1'b0, 1'b0, 32'd0,        32'd0};

      // Async reset state, no clock edge needed
      #1;
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_hi", {32'd0, hi}, 64'd0);
      chk("reset_lo", {32'd0, lo}, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         push_exp(vecs[i].upd_hi ? vecs[i].hi : m_hi,
                  vecs[i].upd_lo ? vecs[i].lo : m_lo, vecs[i].cyc);
         issue(vecs[i].op, vecs[i].cancel, vecs[i].rs, vecs[i].rt);
         wait_done($sformatf("vec%0d", i), 0, 1'b0);
      end

      // Back-to-back MTHI then MTLO
      start = 1'b1; op = MDU_MTHI; rs_val = 32'h12345678;
      @(negedge clk);
      chk("mthi_hi", {32'd0, hi}, 64'h12345678);
      chk("mthi_busy", {63'd0, busy}, 64'd0);
      op = MDU_MTLO; rs_val = 32'h9ABCDEF0;
      @(negedge clk);
      start = 1'b0;
      chk("mtlo_lo", {32'd0, lo}, 64'h9ABCDEF0);
      chk("mtlo_hi_kept", {32'd0, hi}, 64'h12345678);
      chk("mtlo_busy", {63'd0, busy}, 64'd0);
      m_hi = 32'h12345678;
      m_lo = 32'h9ABCDEF0;

      // Cancel pulse mid-RUN must not abort
      push_exp(32'd0, 32'd35, 8'd5);
      issue(MDU_MULT, 1'b0, 32'd5, 32'd7);
      wait_done("cancel_in_run", 2, 1'b0);

      // Stray DIV start during a MULT is ignored
      push_exp(32'd0, 32'd42, 8'd5);
      issue(MDU_MULT, 1'b0, 32'd6, 32'd7);
      wait_done("start_in_run", 2, 1'b1);
      begin
         int nb;
         nb = 0;
         for (int k = 0; k < 12; k++) begin
            if (busy !== 1'b0) nb++;
            @(negedge clk);
         end
         chk("ignored_div_busy", 64'(nb), 64'd0);
         chk("ignored_div_lo", {32'd0, lo}, 64'd42);
      end

      // Reset asserted mid-DIV clears everything immediately
      issue(MDU_DIV, 1'b0, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midrun_reset_busy", {63'd0, busy}, 64'd0);
      chk("midrun_reset_hi", {32'd0, hi}, 64'd0);
      chk("midrun_reset_lo", {32'd0, lo}, 64'd0);
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("post_reset_busy", {63'd0, busy}, 64'd0);
      push_exp(32'hFFFFFFFF, 32'hFFFFFFFA, 8'd5);
      issue(MDU_MULT, 1'b0, 32'hFFFFFFFE, 32'd3);
      wait_done("post_reset_mult", 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
